rv_mem_arb: RTL

Two-port arbiter that shares the single-port unified instruction/data memory of the multicycle RISC-V core between the core (`cpu_*`) and an external requester (`ext_*`), such as a program loader or debug unit. It serialises accesses, issues them to memory, and tracks the fixed read latency. It routes read data and a read-valid strobe back to the owning requester. The block sits between `rv_ctl`/datapath memory signals and the memory macro.

---
 rtl/rv_mem_arb.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/rv_mem_arb.sv
// rv_mem_arb: shares the single-port unified I/D memory between the core (cpu_*) and an
// external requester (ext_*), such as a loader or debug unit.
// Accesses are serialised. Writes complete at grant. A read keeps the arbiter busy until
// its rvalid cycle, MEM_LAT cycles after the grant. A new grant may coincide with that
// rvalid cycle.
//
// Ports:
//   clk, rst                                 clock, asynchronous active-high reset
//   cpu_req/we/addr/wdata -> cpu_gnt         core request, single-cycle grant pulse
//   cpu_rvalid, cpu_rdata                    core read return (rdata mirrors mem_rdata)
//   ext_*                                    same set of ports for the external requester
//   mem_en/we/addr/wdata, mem_rdata          memory macro side
//
// Build option RV_MEM_ARB_RR_EN: round-robin between the two requesters. When it is
// undefined, the CPU has fixed priority and an EXT starvation guard applies.
module rv_mem_arb #(
  parameter int unsigned AW      = 32,
  parameter int unsigned DW      = 32,
  parameter int unsigned MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_gnt,
  output logic          cpu_rvalid,
  output logic [DW-1:0] cpu_rdata,
  input  logic          ext_req,
  input  logic          ext_we,
  input  logic [AW-1:0] ext_addr,
  input  logic [DW-1:0] ext_wdata,
  output logic          ext_gnt,
  output logic          ext_rvalid,
  output logic [DW-1:0] ext_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata
);

  localparam logic       OwnCpu = 1'b0;
  localparam logic       OwnExt = 1'b1;
  localparam logic [1:0] LatM1  = 2'(MEM_LAT - 1);

  typedef enum logic [0:0] {StIdle, StRdWait} state_e;

  state_e     state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  // Owner of the outstanding read; also the last-granted requester.
  logic       owner_q, owner_d;

  logic eligible, rd_done, ext_wins, gnt_c, gnt_e, gnt_we;

  assign rd_done  = (state_q == StRdWait) && (cnt_q == 2'd0);
  // Grants are suppressed while rst is asserted so every strobe reads 0 in reset.
  assign eligible = !rst && ((state_q == StIdle) || rd_done);

`ifdef RV_MEM_ARB_RR_EN
  // On a tie, the requester opposite the last-granted one wins.
  assign ext_wins = !cpu_req || (owner_q == OwnCpu);
`else
  logic [2:0] ext_starve_q, ext_starve_d;

  // Once EXT has been passed over 7 times, it overrides CPU priority.
  assign ext_wins = !cpu_req || (ext_starve_q == 3'd7);

  always_comb begin
    ext_starve_d = ext_starve_q;
    if (gnt_e) begin
      ext_starve_d = 3'd0;
    end else if (gnt_c && ext_req && (ext_starve_q != 3'd7)) begin
      ext_starve_d = ext_starve_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ext_starve_q <= 3'd0;
    end else begin
      ext_starve_q <= ext_starve_d;
    end
  end
`endif

  assign gnt_e = eligible && ext_req && ext_wins;
  assign gnt_c = eligible && cpu_req && !gnt_e;

  always_comb begin
    cpu_gnt    = gnt_c;
    ext_gnt    = gnt_e;
    cpu_rvalid = rd_done && (owner_q == OwnCpu);
    ext_rvalid = rd_done && (owner_q == OwnExt);
    cpu_rdata  = mem_rdata;
    ext_rdata  = mem_rdata;
    mem_en     = gnt_c || gnt_e;
    gnt_we     = gnt_e ? ext_we : cpu_we;
    mem_we     = mem_en && gnt_we;
    mem_addr   = '0;
    mem_wdata  = '0;
    if (gnt_e) begin
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (gnt_c) begin
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    if (state_q == StRdWait) begin
      if (cnt_q != 2'd0) begin
        cnt_d = cnt_q - 2'd1;
      end else begin
        state_d = StIdle;
      end
    end
    if (mem_en) begin
      owner_d = gnt_e ? OwnExt : OwnCpu;
      if (!gnt_we) begin
        state_d = StRdWait;
        cnt_d   = LatM1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      owner_q <= OwnExt;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
    end
  end

endmodule
